// File: rtl/gnn_collect_pkg.sv
// Shared types and constants for the GNN result collector: FSM states, node/slot geometry
// and the slot-index helper used to locate a node's class score in the packed bus.
package gnn_collect_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      COLLECT = 2'd2,
      SEND    = 2'd3
   } state_e;

   localparam int unsigned NUM_NODES   = 4;
   localparam int unsigned NUM_CLASSES = 2;
   localparam int unsigned NUM_SLOTS   = NUM_NODES * NUM_CLASSES;

   function automatic int unsigned slot(input int unsigned node, input int unsigned k);
      return node * NUM_CLASSES + k;
   endfunction

endpackage

// File: rtl/gnn_argmax2.sv
// Two-class argmax: picks the larger signed score (ties go to class 0) and reports the
// winning score plus the non-negative winner-minus-loser margin at one extra bit of width.
module gnn_argmax2 #(
   parameter int unsigned W = 21
) (
   input  logic signed [W-1:0] score0_i,
   input  logic signed [W-1:0] score1_i,
   output logic                class_o,
   output logic        [W-1:0] win_o,
   output logic        [W:0]   margin_o
);

   logic [W-1:0] lose;

   always_comb begin
      class_o  = (score1_i > score0_i);
      win_o    = class_o ? score1_i : score0_i;
      lose     = class_o ? score0_i : score1_i;
      // Sign-extend both operands so the full signed range cannot overflow.
      margin_o = {win_o[W-1], win_o} - {lose[W-1], lose};
   end

endmodule

// File: rtl/gnn_result_collector.sv
// Collects the eight per-node output scores after a settle window, computes per-node
// argmax/margin and streams four result beats over valid/ready, with frame and error status.
module gnn_result_collector
   import gnn_collect_pkg::*;
#(
   parameter int unsigned W              = 21,
   parameter int unsigned SETTLE_CYCLES  = 6,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned FCW            = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   arm,
   input  logic [8*W-1:0]         score_in,
   input  logic [7:0]             score_rdy,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [1:0]             res_node,
   output logic                   res_class,
   output logic [W-1:0]           res_score,
   output logic [W:0]             res_margin,
   output logic                   res_last,
   output logic                   busy,
   output logic [FCW-1:0]         frame_cnt,
   output logic                   err_timeout,
   output logic                   err_arm_busy
);

   localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SCW-1:0] SETTLE_LOAD =
      SCW'(SETTLE_CYCLES - ((SETTLE_CYCLES > 0) ? 1 : 0));
   localparam logic [TCW-1:0] TMO_LOAD =
      TCW'(TIMEOUT_CYCLES - ((TIMEOUT_CYCLES > 0) ? 1 : 0));

   state_e                     state_q, state_d;
   logic [SCW-1:0]             set_q, set_d;
   logic [TCW-1:0]             tmo_q, tmo_d;
   logic [NUM_SLOTS-1:0]       cap_q, cap_d;
   logic [NUM_SLOTS*W-1:0]     sc_q, sc_d;
   logic [1:0]                 idx_q, idx_d;
   logic                       valid_q, valid_d;
   logic [1:0]                 node_q, node_d;
   logic                       cls_q, cls_d;
   logic [W-1:0]               rsc_q, rsc_d;
   logic [W:0]                 mg_q, mg_d;
   logic [FCW-1:0]             fc_q, fc_d;
   logic                       etmo_q, etmo_d;
   logic                       earm_q, earm_d;

   logic [NUM_SLOTS-1:0]       new_cap;
   logic [1:0]                 beat_sel;
   logic                       load_beat;

   logic                       am_cls [NUM_NODES];
   logic [W-1:0]               am_win [NUM_NODES];
   logic [W:0]                 am_mg  [NUM_NODES];

   for (genvar n = 0; n < NUM_NODES; n++) begin : g_argmax
      gnn_argmax2 #(.W(W)) u_argmax (
         .score0_i (sc_q[slot(n, 0)*W +: W]),
         .score1_i (sc_q[slot(n, 1)*W +: W]),
         .class_o  (am_cls[n]),
         .win_o    (am_win[n]),
         .margin_o (am_mg[n])
      );
   end

   always_comb begin
      state_d   = state_q;
      set_d     = set_q;
      tmo_d     = tmo_q;
      cap_d     = cap_q;
      sc_d      = sc_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      node_d    = node_q;
      cls_d     = cls_q;
      rsc_d     = rsc_q;
      mg_d      = mg_q;
      fc_d      = fc_q;
      etmo_d    = etmo_q;
      earm_d    = earm_q;
      new_cap   = score_rdy & ~cap_q;
      beat_sel  = idx_q;
      load_beat = 1'b0;

      case (state_q)
         IDLE: begin
            if (arm) begin
               etmo_d = 1'b0;
               earm_d = 1'b0;
               cap_d  = '0;
               if (SETTLE_CYCLES == 0) begin
                  tmo_d   = TMO_LOAD;
                  state_d = COLLECT;
               end else begin
                  set_d   = SETTLE_LOAD;
                  state_d = SETTLE;
               end
            end
         end

         SETTLE: begin
            if (set_q == '0) begin
               tmo_d   = TMO_LOAD;
               state_d = COLLECT;
            end else begin
               set_d = set_q - 1'b1;
            end
         end

         COLLECT: begin
            cap_d = cap_q | new_cap;
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
               if (new_cap[s]) sc_d[s*W +: W] = score_in[s*W +: W];
            end
            // Completion this cycle wins over an expiring timeout.
            if (&(cap_q | new_cap)) begin
               idx_d   = '0;
               state_d = SEND;
            end else if (tmo_q == '0) begin
               etmo_d  = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end

         SEND: begin
            if (!valid_q) begin
               load_beat = 1'b1;
               valid_d   = 1'b1;
            end else if (res_ready) begin
               if (idx_q == 2'd3) begin
                  valid_d = 1'b0;
                  fc_d    = fc_q + 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d     = idx_q + 2'd1;
                  beat_sel  = idx_q + 2'd1;
                  load_beat = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      if (load_beat) begin
         node_d = beat_sel;
         cls_d  = am_cls[beat_sel];
         rsc_d  = am_win[beat_sel];
         mg_d   = am_mg[beat_sel];
      end

      if (arm && (state_q != IDLE)) earm_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         set_q   <= '0;
         tmo_q   <= '0;
         cap_q   <= '0;
         sc_q    <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         node_q  <= '0;
         cls_q   <= 1'b0;
         rsc_q   <= '0;
         mg_q    <= '0;
         fc_q    <= '0;
         etmo_q  <= 1'b0;
         earm_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         tmo_q   <= tmo_d;
         cap_q   <= cap_d;
         sc_q    <= sc_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         node_q  <= node_d;
         cls_q   <= cls_d;
         rsc_q   <= rsc_d;
         mg_q    <= mg_d;
         fc_q    <= fc_d;
         etmo_q  <= etmo_d;
         earm_q  <= earm_d;
      end
   end

   assign res_valid    = valid_q;
   assign res_node     = node_q;
   assign res_class    = cls_q;
   assign res_score    = rsc_q;
   assign res_margin   = mg_q;
   assign res_last     = valid_q && (node_q == 2'd3);
   assign busy         = (state_q != IDLE);
   assign frame_cnt    = fc_q;
   assign err_timeout  = etmo_q;
   assign err_arm_busy = earm_q;

endmodule

// File: doc/gnn_result_collector.md
Name: gnn_result_collector

Overview:
- Downstream stage of the 4-node GNN top. Captures the eight per-node output-layer scores (2 per node) once their ready flags assert, after a programmable settle window.
- Computes a per-node argmax class and margin.
- Streams four result beats (node 0..3) over a valid/ready handshake to the host-side consumer.
- Provides frame counting and error flags for timeout and arm-while-busy.

Parameters:
- W, 21, width of each signed output-layer score.
- SETTLE_CYCLES, 6, cycles after arm before capture is enabled (covers GNN pipeline latency; stale ready flags are ignored during this window).
- TIMEOUT_CYCLES, 64, maximum cycles spent in COLLECT before abort.
- FCW, 8, frame counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- arm  in  1  single-cycle pulse; starts a frame (issued alongside the GNN in_ready)
- score_in  in  8*W  packed scores; slot s=2*node+k occupies bits [s*W +: W], signed
- score_rdy  in  8  per-slot ready flags, same slot indexing
- res_valid  out  1  result beat valid
- res_ready  in  1  consumer accepts beat
- res_node  out  2  node index of beat
- res_class  out  1  argmax class (0 or 1)
- res_score  out  W  winning score, signed
- res_margin  out  W+1  winning minus losing score, unsigned, ≥0
- res_last  out  1  high on node-3 beat
- busy  out  1  state != IDLE
- frame_cnt  out  FCW  completed frames, wraps
- err_timeout  out  1  sticky; set on COLLECT timeout
- err_arm_busy  out  1  sticky; set when arm arrives while busy

Behaviour:
- Reset values:
  - State = IDLE. All outputs 0.
  - Capture registers and captured mask = 0. Counters = 0.
- FSM states: IDLE, SETTLE, COLLECT, SEND.
- IDLE:
  - On arm: clear both err flags, clear captured mask, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - If SETTLE_CYCLES==0, go directly to COLLECT.
- SETTLE:
  - Decrement counter each cycle; at 0 go to COLLECT and load timeout counter.
  - score_rdy is ignored in this state.
- COLLECT:
  - Each cycle, for every slot with score_rdy[s]=1 and captured[s]=0: register score_in slot s and set captured[s].
  - Multiple slots may capture in the same cycle.
  - A captured slot is never overwritten within a frame.
  - When the mask becomes all ones (including captures made this cycle), go to SEND next cycle with beat index 0.
  - Timeout counter decrements each cycle. If it reaches 0 with mask incomplete: set err_timeout, return to IDLE, frame_cnt unchanged, no beats emitted.
- SEND:
  - Per node n: class = 1 iff score1 > score0 (signed compare); ties give class 0.
  - res_score = score of the winning class.
  - res_margin = winning − losing score, computed at W+1 bits.
  - Beat fields are registered. res_valid rises one cycle after entering SEND.
  - Beat n stays stable while res_valid && !res_ready.
  - Advance on res_valid && res_ready. Beats are back-to-back capable: valid stays high, next node's fields are presented the following cycle.
  - After beat 3 (res_last=1) handshakes: drop res_valid, increment frame_cnt (wraps at 2^FCW), go to IDLE.
- arm in any state other than IDLE: ignored, err_arm_busy set. arm in the same cycle the FSM returns to IDLE is also ignored.
- res_ready while res_valid=0: no effect.
- Async reset mid-frame: immediate return to reset values; a partially sent frame is discarded and not counted.
- No combinational path from res_ready to res_valid or beat fields.

Decomposition:
- Package gnn_collect_pkg holds:
  - state enum (IDLE, SETTLE, COLLECT, SEND)
  - NUM_NODES=4, NUM_CLASSES=2, NUM_SLOTS=8
  - slot-index helper function slot(node, k)
- One sub-module, gnn_argmax2: combinational compare of two signed W-bit scores producing class, winning score, and margin. Four instances (one per node), or one muxed by beat index.

Test Plan:
- Nominal frame:
  - Stimulus: arm; after settle, all score_rdy=8'hFF. Node0 (5,−3), node1 (−2,7), node2 (4,4), node3 (−100,−99).
  - Response: beats (0,0,5,8), (1,1,7,9), (2,0,4,0), (3,1,−99,1). res_last only on node 3. frame_cnt=1.
- Stale flags:
  - Stimulus: score_rdy=8'hFF held through SETTLE while score_in changes each cycle.
  - Response: values captured are those present on the first COLLECT cycle, not earlier ones.
- Staggered capture:
  - Stimulus: slots assert one per cycle in order 7..0 with distinct values; each slot's value changes after its flag.
  - Response: first-seen value kept per slot. SEND entered one cycle after slot 0 captures.
- Backpressure:
  - Stimulus: res_ready low for 5 cycles on beat 1, toggling afterwards.
  - Response: beat 1 fields stable while stalled; exactly 4 handshakes; no beat dropped or duplicated.
- Timeout and busy-arm:
  - Stimulus: only 7 slots ready, TIMEOUT_CYCLES=64; also pulse arm while in SETTLE.
  - Response: err_arm_busy=1 immediately. err_timeout=1 after 64 COLLECT cycles, then IDLE, no beats, frame_cnt unchanged. Next arm clears both flags.
- Reset and wrap:
  - Stimulus: assert rst_n low during beat 2 of SEND.
  - Response: all outputs 0 asynchronously, frame_cnt=0.
  - Stimulus: with FCW=2, run 4 frames.
  - Response: frame_cnt wraps to 0.
